uart_rx_module: RTL

//  UART receiver paired with the TxModule transmit path. Oversamples serial Rx with
//  the same Speed (clock cycles per bit) and Parity controls, reassembles a

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_module_if.sv | 21 ++
 rtl/uart_rx_bit_timer.sv | 37 +++
 rtl/uart_rx_module.sv | 95 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the minimum bit period.
// The receiver and the transmit controller both use this package.
package uart_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam logic [3:0] SPEED_MIN = 4'd2;

  // Bit periods below SPEED_MIN cannot hold a mid-bit sample point.
  function automatic logic [3:0] clamp_speed(input logic [3:0] s);
    return (s < SPEED_MIN) ? SPEED_MIN : s;
  endfunction

endpackage

// File: rtl/uart_rx_module_if.sv
// Receiver host-side bundle.
//   Rx, Speed, Parity        : line and frame controls into the receiver
//   Data, DataValid          : received word and its one-cycle strobe
//   ParityError, FrameError  : status of the last frame
//   Busy                     : receiver not idle
// master = line/host side driving the controls, slave = the receiver.
interface uart_rx_module_if #(parameter int DataLength = 9);
  logic                  Rx;
  logic [3:0]            Speed;
  logic                  Parity;
  logic [DataLength-1:0] Data;
  logic                  DataValid;
  logic                  ParityError;
  logic                  FrameError;
  logic                  Busy;

  modport master (output Rx, Speed, Parity,
                  input  Data, DataValid, ParityError, FrameError, Busy);
  modport slave  (input  Rx, Speed, Parity,
                  output Data, DataValid, ParityError, FrameError, Busy);
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit timer for the UART receiver.
//   Clock, Reset : system clock, async active-low reset
//   start        : start edge seen; latch clamped Speed, load half a period
//   run          : frame in progress, timer counts
//   speed        : raw Speed input (sampled only on start)
//   expire       : one-cycle strobe at each sample point
module uart_rx_bit_timer
  import uart_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       run,
  input  logic [3:0] speed,
  output logic       expire
);

  logic [3:0] period, cnt, p_new;

  assign p_new  = clamp_speed(speed);
  assign expire = run && (cnt == 4'd1);

  // Half-period first load centres every later sample in its bit cell;
  // expiry reloads the full period so samples stay one period apart.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      period <= SPEED_MIN;
      cnt    <= '0;
    end else if (start) begin
      period <= p_new;
      cnt    <= p_new >> 1;
    end else if (run) begin
      cnt <= (cnt == 4'd1) ? period : cnt - 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver: synchronizes Rx, detects the start edge, samples each bit
// mid-cell, reassembles a DataLength-bit word LSB first, checks optional even
// parity and the stop bit, and presents the word with a one-cycle DataValid.
//   Clock, Reset : system clock, async active-low reset
//   bus (slave)  : Rx/Speed/Parity in; Data/DataValid/ParityError/FrameError/Busy out
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int DataLength = 9,
  parameter int SyncStages = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  uart_rx_module_if.slave bus
);

  localparam int IW = (DataLength > 1) ? $clog2(DataLength) : 1;

  logic [SyncStages-1:0] sync;
  logic                  rx_s;
  logic [2:0]            state;
  logic                  par_en, par_bit;
  logic [DataLength-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  start, run, expire;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) sync <= '1;
    else        sync <= {sync[SyncStages-2:0], bus.Rx};
  end
  assign rx_s = sync[SyncStages-1];

  // IDLE is only entered with the synchronized line high (reset value, stop
  // sampled 1, false start, WAIT_IDLE exit), so a low level here is a 1->0 edge.
  assign start    = (state == IDLE) && !rx_s;
  assign run      = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
  assign bus.Busy = (state != IDLE);

  uart_rx_bit_timer u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (start),
    .run    (run),
    .speed  (bus.Speed),
    .expire (expire)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      par_en          <= 1'b0;
      par_bit         <= 1'b0;
      shreg           <= '0;
      idx             <= '0;
      bus.Data        <= '0;
      bus.DataValid   <= 1'b0;
      bus.ParityError <= 1'b0;
      bus.FrameError  <= 1'b0;
    end else begin
      bus.DataValid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= START;
          par_en <= bus.Parity;
        end
        START: if (expire) begin
          // line back high at mid start bit: glitch, drop silently
          state <= rx_s ? IDLE : DATA;
          idx   <= '0;
        end
        DATA: if (expire) begin
          shreg[idx] <= rx_s;
          if (idx == IW'(DataLength - 1)) state <= par_en ? PARITY : STOP;
          else                            idx   <= idx + IW'(1);
        end
        PARITY: if (expire) begin
          par_bit <= rx_s;
          state   <= STOP;
        end
        STOP: if (expire) begin
          bus.Data        <= shreg;
          bus.ParityError <= par_en & (^shreg ^ par_bit);
          bus.FrameError  <= ~rx_s;
          bus.DataValid   <= 1'b1;
          // a low stop bit may be a break; wait for the line to recover
          state           <= rx_s ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
